sys_bus_xbar: RTL
=================

// Module: sys_bus_xbar
// PURPOSE
//  Parametrised single-master, NUM_SLV-slave memory-mapped interconnect; successor to the fixed
//  single-cycle system bus. Sits between data_path (master) and dram_ctrl/rom/gpio/uart (slaves).
//  Adds a registered req/ready handshake so slaves may stall, parametrised address map,
//  an error response for unmapped addresses or illegal ops, and an optional watchdog timeout.
// PARAMETERS
//  AW        64              address width
//  DW        64              data width
//  NUM_SLV   4               number of slave ports (1..8)
//  SLV_BASE  {NUM_SLV*AW}    packed base addresses; slave i = bits [i*AW +: AW]
//  SLV_MASK  {NUM_SLV*AW}    packed masks; hit_i = ((m_addr & MASK_i) == BASE_i)
//  TO_CYC    255             watchdog limit in cycles (used only with BUS_TIMEOUT_EN)
// PORTS
//  clk        in   1           system clock, rising edge
//  rst        in   1           synchronous reset, active-high
//  m_req      in   1           master request; held with addr/data/ctrl until m_ready
//  m_addr     in   AW          master address
//  m_wdata    in   DW          master write data
//  m_rd_ctrl  in   3           read size/sign code (0 = no read), dram_ctrl encoding
//  m_wr_ctrl  in   3           write size code (0 = no write), dram_ctrl encoding
//  m_ready    out  1           one-cycle completion pulse
//  m_rdata    out  DW          read data, valid while m_ready=1
//  m_err      out  1           error flag, valid while m_ready=1
//  s_req      out  NUM_SLV     one-hot request to selected slave
//  s_addr     out  AW          broadcast address (registered)
//  s_wdata    out  DW          broadcast write data (registered)
//  s_rd_ctrl  out  3           broadcast read ctrl (registered)
//  s_wr_ctrl  out  3           broadcast write ctrl (registered)
//  s_ready    in   NUM_SLV     per-slave completion; sampled only for selected slave
//  s_rdata    in   NUM_SLV*DW  per-slave read data, slave i = [i*DW +: DW]
// BEHAVIOUR
//  - Reset: state=IDLE; m_ready, m_err, s_req, s_rd_ctrl, s_wr_ctrl = 0; m_rdata, s_addr, s_wdata = 0.
//  - FSM IDLE -> ACCESS -> RESP -> IDLE; IDLE -> RESP directly on error.
//  - IDLE: m_req=1 samples inputs; decode with lowest-index hit winning on overlap.
//    Hit and exactly one of rd/wr ctrl nonzero: register addr/data/ctrl,
//    assert s_req[sel] next cycle, go ACCESS.
//    No hit, or both ctrls zero, or both nonzero: go RESP with err=1, no s_req.
//  - ACCESS: s_req[sel] and s_* outputs held stable; on s_ready[sel]=1 capture
//    s_rdata[sel] (0 for writes), drop s_req, go RESP. s_ready of unselected slaves ignored.
//  - RESP: m_ready=1 for exactly one cycle, m_rdata/m_err driven; next state IDLE.
//  - Latency: m_req sampled cycle N; s_req high from N+1; s_ready seen at cycle M>=N+1;
//    m_ready at M+1 (min 2 cycles). Error path: m_ready at N+1.
//  - Back-to-back: in IDLE the cycle after RESP a still-high m_req is a NEW transaction;
//    master must drop or change m_req in the cycle m_ready is seen. One outstanding txn max.
//  - m_req dropping during ACCESS is ignored; transaction completes.
//  - Reset mid-transaction: rst=1 in any state forces IDLE and zeros s_req in the same edge;
//    no m_ready for the aborted transaction.
//  - m_rdata holds its last value outside RESP; m_err=0 outside RESP.
// CONFIGURATION
//  BUS_TIMEOUT_EN defined: counter cleared on entry to ACCESS, incremented each ACCESS cycle;
//    when it reaches TO_CYC without s_ready[sel], drop s_req, go RESP with m_err=1, m_rdata=0.
//    A s_ready arriving in the same cycle as the limit wins (normal completion).
//  BUS_TIMEOUT_EN undefined: no counter; ACCESS waits indefinitely for s_ready[sel].
// TESTING
//  1 read slave1 (BASE=0x1000_0000, MASK=0xFFFF_F000), s_ready at +3 cycles, rdata=0xDEAD_BEEF
//    -> s_req=4'b0010 for 3 cycles, m_ready 1 cycle later, m_rdata=0xDEAD_BEEF, m_err=0.
//  2 write 0x55 (wr_ctrl=1) to slave0 with s_ready same cycle as s_req -> m_ready 2 cycles
//    after m_req, s_wdata=0x55, s_wr_ctrl=1, m_rdata=0, m_err=0.
//  3 read addr 0xFFFF_0000 unmapped -> no s_req, m_ready at N+1 with m_err=1.
//  4 m_rd_ctrl=1 and m_wr_ctrl=1 together -> error response, no s_req; both ctrl 0 -> same.
//  5 rst asserted in 2nd ACCESS cycle -> s_req=0 next edge, no m_ready; a fresh read then
//    completes normally.
//  6 BUS_TIMEOUT_EN, TO_CYC=8, slave never ready -> s_req high 8 cycles, m_ready with m_err=1;
//    without macro -> s_req remains high after 100 cycles, no m_ready.

Source files
------------

// File: rtl/sys_bus_xbar_if.sv
// rtl/sys_bus_xbar_if.sv - master-side and slave-side signal bundle for sys_bus_xbar
interface sys_bus_xbar_if #(
   parameter int AW      = 64,
   parameter int DW      = 64,
   parameter int NUM_SLV = 4
);
   logic                  m_req;
   logic [AW-1:0]         m_addr;
   logic [DW-1:0]         m_wdata;
   logic [2:0]            m_rd_ctrl;
   logic [2:0]            m_wr_ctrl;
   logic                  m_ready;
   logic [DW-1:0]         m_rdata;
   logic                  m_err;

   logic [NUM_SLV-1:0]    s_req;
   logic [AW-1:0]         s_addr;
   logic [DW-1:0]         s_wdata;
   logic [2:0]            s_rd_ctrl;
   logic [2:0]            s_wr_ctrl;
   logic [NUM_SLV-1:0]    s_ready;
   logic [NUM_SLV*DW-1:0] s_rdata;

   // data_path view
   modport master (
      output m_req, m_addr, m_wdata, m_rd_ctrl, m_wr_ctrl,
      input  m_ready, m_rdata, m_err
   );

   // view shared by the slave devices
   modport slave (
      input  s_req, s_addr, s_wdata, s_rd_ctrl, s_wr_ctrl,
      output s_ready, s_rdata
   );

   modport xbar (
      input  m_req, m_addr, m_wdata, m_rd_ctrl, m_wr_ctrl,
      output m_ready, m_rdata, m_err,
      output s_req, s_addr, s_wdata, s_rd_ctrl, s_wr_ctrl,
      input  s_ready, s_rdata
   );
endinterface

// File: rtl/sys_bus_xbar.sv
// rtl/sys_bus_xbar.sv - single-master, NUM_SLV-slave interconnect with stall and error response
// Optional access watchdog enabled by defining BUS_TIMEOUT_EN.
module sys_bus_xbar #(
   parameter int                    AW       = 64,
   parameter int                    DW       = 64,
   parameter int                    NUM_SLV  = 4,
   parameter logic [NUM_SLV*AW-1:0] SLV_BASE = {64'h3000_0000, 64'h2000_0000,
                                                64'h1000_0000, 64'h0000_0000},
   parameter logic [NUM_SLV*AW-1:0] SLV_MASK = {4{64'hFFFF_FFFF_F000_0000}},
   parameter int                    TO_CYC   = 255
) (
   input logic          clk,
   input logic          rst,
   sys_bus_xbar_if.xbar bus
);
   localparam int SW = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;

   if (NUM_SLV < 1 || NUM_SLV > 8 || TO_CYC < 1) begin : g_bad_cfg
      $error("sys_bus_xbar: NUM_SLV must be 1..8 and TO_CYC >= 1");
   end

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t             state, state_d;
   logic               hit;
   logic [SW-1:0]      hit_idx;
   logic               legal;
   logic               load, finish, fail;
   logic [SW-1:0]      sel_q;
   logic [DW-1:0]      rdata_arr [NUM_SLV];

   logic [NUM_SLV-1:0] s_req_q;
   logic [AW-1:0]      s_addr_q;
   logic [DW-1:0]      s_wdata_q;
   logic [2:0]         s_rd_ctrl_q;
   logic [2:0]         s_wr_ctrl_q;
   logic               m_ready_q;
   logic [DW-1:0]      m_rdata_q;
   logic               m_err_q;

`ifdef BUS_TIMEOUT_EN
   localparam int CW = $clog2(TO_CYC + 1);
   logic [CW-1:0] cnt;
`endif

   // Scan downward so the lowest-index hit overwrites any higher one on overlap.
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int i = NUM_SLV - 1; i >= 0; i--) begin
         if ((bus.m_addr & SLV_MASK[i*AW +: AW]) == SLV_BASE[i*AW +: AW]) begin
            hit     = 1'b1;
            hit_idx = SW'(i);
         end
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_SLV; i++) begin
         rdata_arr[i] = bus.s_rdata[i*DW +: DW];
      end
   end

   assign legal = hit && ((bus.m_rd_ctrl != 3'd0) != (bus.m_wr_ctrl != 3'd0));

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_d;
      end
   end

   always_comb begin
      state_d = state;
      load    = 1'b0;
      finish  = 1'b0;
      fail    = 1'b0;
      unique case (state)
         IDLE: begin
            if (bus.m_req) begin
               if (legal) begin
                  load    = 1'b1;
                  state_d = ACCESS;
               end else begin
                  fail    = 1'b1;
                  state_d = RESP;
               end
            end
         end
         ACCESS: begin
            if (bus.s_ready[sel_q]) begin
               finish  = 1'b1;
               state_d = RESP;
            end
`ifdef BUS_TIMEOUT_EN
            else if (cnt == CW'(TO_CYC - 1)) begin
               fail    = 1'b1;
               state_d = RESP;
            end
`endif
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sel_q       <= '0;
         s_req_q     <= '0;
         s_addr_q    <= '0;
         s_wdata_q   <= '0;
         s_rd_ctrl_q <= 3'd0;
         s_wr_ctrl_q <= 3'd0;
         m_ready_q   <= 1'b0;
         m_rdata_q   <= '0;
         m_err_q     <= 1'b0;
      end else begin
         m_ready_q <= finish | fail;
         m_err_q   <= fail;
         if (load) begin
            sel_q       <= hit_idx;
            s_req_q     <= NUM_SLV'(1) << hit_idx;
            s_addr_q    <= bus.m_addr;
            s_wdata_q   <= bus.m_wdata;
            s_rd_ctrl_q <= bus.m_rd_ctrl;
            s_wr_ctrl_q <= bus.m_wr_ctrl;
         end else if (finish | fail) begin
            s_req_q <= '0;
         end
         // Writes and failed accesses return zero data.
         if (finish) begin
            m_rdata_q <= (s_rd_ctrl_q != 3'd0) ? rdata_arr[sel_q] : '0;
         end else if (fail) begin
            m_rdata_q <= '0;
         end
      end
   end

`ifdef BUS_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (rst || load) begin
         cnt <= '0;
      end else if (state == ACCESS) begin
         cnt <= cnt + 1'b1;
      end
   end
`endif

   assign bus.s_req     = s_req_q;
   assign bus.s_addr    = s_addr_q;
   assign bus.s_wdata   = s_wdata_q;
   assign bus.s_rd_ctrl = s_rd_ctrl_q;
   assign bus.s_wr_ctrl = s_wr_ctrl_q;
   assign bus.m_ready   = m_ready_q;
   assign bus.m_rdata   = m_rdata_q;
   assign bus.m_err     = m_err_q;
endmodule
